// File: rtl/axil_bridge_pkg.sv
// rtl/axil_bridge_pkg.sv - shared FSM encodings and AXI response codes for the register bridge
package axil_bridge_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/bridge_watchdog.sv
// rtl/bridge_watchdog.sv - saturating per-access cycle counter that flags a missing downstream ack
module bridge_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  // Expired means this cycle is the TIMEOUT_CYC-th enabled cycle since the last clear.
  assign expired = (count >= CW'(TIMEOUT_CYC - 1));

  // Count enabled cycles, restart on clear, hold at the limit instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != CW'(TIMEOUT_CYC))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axil_disp_reg_bridge.sv
// rtl/axil_disp_reg_bridge.sv - AXI4-Lite slave to valid/ack register bridge with per-path watchdog
module axil_disp_reg_bridge
  import axil_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [ADDR_WIDTH-1:0]     oWriteAddress,
  output logic [DATA_WIDTH-1:0]     oWriteData,
  output logic                      oWriteValid,
  input  logic                      iWriteAck,
  output logic [ADDR_WIDTH-1:0]     oReadAddress,
  output logic                      oReadValid,
  input  logic [DATA_WIDTH-1:0]     iReadData,
  input  logic                      iReadAck
);

  w_state_t                  w_state;
  r_state_t                  r_state;
  logic                      aw_done;
  logic                      w_done;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      wr_expired;
  logic                      rd_expired;

  bridge_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wr_wd (
    .clk     (iClock),
    .rst     (iReset),
    .clear   (w_state != W_REQ),
    .en      (w_state == W_REQ),
    .expired (wr_expired)
  );

  bridge_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rd_wd (
    .clk     (iClock),
    .rst     (iReset),
    .clear   (r_state != R_REQ),
    .en      (r_state == R_REQ),
    .expired (rd_expired)
  );

  // Write path: collect AW and W in any order, issue one downstream write, return B.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      w_state       <= W_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wstrb_q       <= '0;
      s_awready     <= 1'b0;
      s_wready      <= 1'b0;
      s_bvalid      <= 1'b0;
      s_bresp       <= AXI_RESP_OKAY;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oWriteValid   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_done && w_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            // Partial strobes cannot be expressed downstream, so they are refused outright.
            if (wstrb_q == '1) begin
              w_state     <= W_REQ;
              oWriteValid <= 1'b1;
            end else begin
              w_state  <= W_RESP;
              s_bvalid <= 1'b1;
              s_bresp  <= AXI_RESP_SLVERR;
            end
          end else begin
            if (s_awvalid && s_awready) begin
              oWriteAddress <= s_awaddr;
              aw_done       <= 1'b1;
              s_awready     <= 1'b0;
            end else if (!aw_done) begin
              s_awready <= 1'b1;
            end
            if (s_wvalid && s_wready) begin
              oWriteData <= s_wdata;
              wstrb_q    <= s_wstrb;
              w_done     <= 1'b1;
              s_wready   <= 1'b0;
            end else if (!w_done) begin
              s_wready <= 1'b1;
            end
          end
        end
        W_REQ: begin
          if (iWriteAck) begin
            oWriteValid <= 1'b0;
            s_bvalid    <= 1'b1;
            s_bresp     <= AXI_RESP_OKAY;
            w_state     <= W_RESP;
          end else if (wr_expired) begin
            oWriteValid <= 1'b0;
            s_bvalid    <= 1'b1;
            s_bresp     <= AXI_RESP_SLVERR;
            w_state     <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path: accept AR, hold one downstream read until ack or timeout, return R.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state      <= R_IDLE;
      s_arready    <= 1'b0;
      s_rvalid     <= 1'b0;
      s_rresp      <= AXI_RESP_OKAY;
      s_rdata      <= '0;
      oReadAddress <= '0;
      oReadValid   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            oReadAddress <= s_araddr;
            s_arready    <= 1'b0;
            oReadValid   <= 1'b1;
            r_state      <= R_REQ;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_REQ: begin
          // Dropping valid on the ack edge keeps a block that re-acks on held valid from seeing a second read.
          if (iReadAck) begin
            s_rdata    <= iReadData;
            s_rresp    <= AXI_RESP_OKAY;
            oReadValid <= 1'b0;
            s_rvalid   <= 1'b1;
            r_state    <= R_RESP;
          end else if (rd_expired) begin
            s_rdata    <= ERR_RDATA;
            s_rresp    <= AXI_RESP_SLVERR;
            oReadValid <= 1'b0;
            s_rvalid   <= 1'b1;
            r_state    <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_disp_reg_bridge.sv
// tb/tb_axil_disp_reg_bridge.sv - directed self-checking bench for the AXI-Lite register bridge
module tb_axil_disp_reg_bridge;

  localparam int TO = 16;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] oWriteAddress;
  logic [31:0] oWriteData;
  logic        oWriteValid;
  logic        iWriteAck = 1'b1;
  logic [31:0] oReadAddress;
  logic        oReadValid;
  logic [31:0] iReadData = '0;
  logic        iReadAck = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int rd_mode = 0;
  int rv_cnt  = 0;

  always #5 iClock = ~iClock;

  axil_disp_reg_bridge #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .TIMEOUT_CYC (TO),
    .ERR_RDATA   (32'hDEAD_BEEF)
  ) dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .s_awaddr      (s_awaddr),
    .s_awvalid     (s_awvalid),
    .s_awready     (s_awready),
    .s_wdata       (s_wdata),
    .s_wstrb       (s_wstrb),
    .s_wvalid      (s_wvalid),
    .s_wready      (s_wready),
    .s_bresp       (s_bresp),
    .s_bvalid      (s_bvalid),
    .s_bready      (s_bready),
    .s_araddr      (s_araddr),
    .s_arvalid     (s_arvalid),
    .s_arready     (s_arready),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oWriteValid   (oWriteValid),
    .iWriteAck     (iWriteAck),
    .oReadAddress  (oReadAddress),
    .oReadValid    (oReadValid),
    .iReadData     (iReadData),
    .iReadAck      (iReadAck)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One cycle: move to the negedge, then let the downstream read model react.
  task automatic step();
    @(negedge iClock);
    rv_cnt   = oReadValid ? rv_cnt + 1 : 0;
    iReadAck = (rd_mode == 1) && oReadValid && (rv_cnt == 2);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, output int lat, output int wv_n,
                          output logic [1:0] resp, output logic [31:0] sa,
                          output logic [31:0] sd, output logic done);
    logic aw_hs, w_hs, aw_sent, started;
    lat = 0; wv_n = 0; resp = 2'b11; sa = '0; sd = '0; done = 1'b0; started = 1'b0;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    s_awvalid = (w_lead == 0); aw_sent = (w_lead == 0);
    for (int i = 0; i < 100; i++) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      step();
      if (aw_hs) begin s_awvalid = 1'b0; started = 1'b1; end
      if (w_hs) s_wvalid = 1'b0;
      if (started) lat++;
      if (!aw_sent && (i + 1 >= w_lead)) begin s_awvalid = 1'b1; aw_sent = 1'b1; end
      if (oWriteValid) begin wv_n++; sa = oWriteAddress; sd = oWriteData; end
      if (s_bvalid) begin resp = s_bresp; done = 1'b1; break; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1; step(); s_bready = 1'b0;
    check("wr_bvalid_clear", s_bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output int rv_n, output int ack_n,
                         output logic [31:0] rd, output logic [1:0] rr, output logic [31:0] ra,
                         output logic done);
    logic hs, started;
    lat = 0; rv_n = 0; ack_n = 0; rd = '0; rr = 2'b11; ra = '0; done = 1'b0; started = 1'b0;
    s_araddr = a; s_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      hs = s_arvalid && s_arready;
      step();
      if (hs) begin s_arvalid = 1'b0; started = 1'b1; end
      if (started) lat++;
      if (oReadValid) begin rv_n++; ra = oReadAddress; end
      if (iReadAck) ack_n++;
      if (s_rvalid) begin rd = s_rdata; rr = s_rresp; done = 1'b1; break; end
    end
    s_arvalid = 1'b0;
    s_rready = 1'b1; step(); s_rready = 1'b0;
    check("rd_rvalid_clear", s_rvalid, 0);
  endtask

  initial begin
    int lat, vn, an;
    logic [1:0] resp, b0, r0;
    logic [31:0] sa, sd, rd, wa, ra, rd0;
    logic done, stable, ar_hs, aw_hs, w_hs;

    // Reset state
    step(); step();
    check("rst_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, oWriteValid, oReadValid,
                          s_bresp, s_rresp}, 0);
    check("rst_data", {oWriteAddress, oWriteData}, 0);
    iReset = 1'b0;
    step(); step();

    // T1: AW+W together, ack tied high
    do_write(32'h0, 32'h100, 4'hF, 0, lat, vn, resp, sa, sd, done);
    check("t1_done", done, 1);
    check("t1_latency", lat, 3);
    check("t1_wvalid_cycles", vn, 1);
    check("t1_waddr", sa, 32'h0);
    check("t1_wdata", sd, 32'h100);
    check("t1_bresp", resp, 2'b00);

    // T2: W leads AW by two cycles with a partial strobe
    step(); step();
    do_write(32'h4, 32'hCAFE, 4'h3, 2, lat, vn, resp, sa, sd, done);
    check("t2_done", done, 1);
    check("t2_no_wvalid", vn, 0);
    check("t2_latency", lat, 2);
    check("t2_bresp", resp, 2'b10);
    step(); step();
    do_write(32'h4, 32'hCAFE, 4'hF, 0, lat, vn, resp, sa, sd, done);
    check("t2_next_bresp", resp, 2'b00);
    check("t2_next_wvalid", vn, 1);
    check("t2_next_wdata", sd, 32'hCAFE);

    // T3: read with ack one cycle after valid
    step(); step();
    rd_mode = 1; iReadData = 32'h1234;
    do_read(32'h3C, lat, vn, an, rd, resp, ra, done);
    check("t3_done", done, 1);
    check("t3_rdata", rd, 32'h1234);
    check("t3_rresp", resp, 2'b00);
    check("t3_rvalid_cycles", vn, 2);
    check("t3_ack_count", an, 1);
    check("t3_latency", lat, 3);
    check("t3_raddr", ra, 32'h3C);

    // T4: read never acked, then a normal read
    step(); step();
    rd_mode = 0;
    do_read(32'h40, lat, vn, an, rd, resp, ra, done);
    check("t4_done", done, 1);
    check("t4_req_cycles", vn, TO);
    check("t4_rdata", rd, 32'hDEAD_BEEF);
    check("t4_rresp", resp, 2'b10);
    step(); step();
    rd_mode = 1; iReadData = 32'h5678;
    do_read(32'h44, lat, vn, an, rd, resp, ra, done);
    check("t4_next_rresp", resp, 2'b00);
    check("t4_next_rdata", rd, 32'h5678);

    // T5: concurrent write and read with both responses stalled
    step(); step();
    iReadData = 32'hC0DE; wa = '0; ra = '0;
    s_awaddr = 32'h08; s_wdata = 32'h55AA; s_wstrb = 4'hF; s_araddr = 32'h0C;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      aw_hs = s_awvalid && s_awready; w_hs = s_wvalid && s_wready; ar_hs = s_arvalid && s_arready;
      step();
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs) s_wvalid = 1'b0;
      if (ar_hs) s_arvalid = 1'b0;
      if (oWriteValid) wa = oWriteAddress;
      if (oReadValid) ra = oReadAddress;
      if (s_bvalid && s_rvalid) begin done = 1'b1; break; end
    end
    check("t5_done", done, 1);
    b0 = s_bresp; r0 = s_rresp; rd0 = s_rdata; stable = 1'b1;
    repeat (5) begin
      step();
      if (!(s_bvalid && s_rvalid && s_bresp == b0 && s_rresp == r0 && s_rdata == rd0)) stable = 1'b0;
    end
    check("t5_stable", stable, 1);
    check("t5_bresp", b0, 2'b00);
    check("t5_rresp", r0, 2'b00);
    check("t5_rdata", rd0, 32'hC0DE);
    check("t5_waddr", wa, 32'h08);
    check("t5_raddr", ra, 32'h0C);
    s_bready = 1'b1; s_rready = 1'b1; step(); s_bready = 1'b0; s_rready = 1'b0;
    check("t5_clear", {s_bvalid, s_rvalid}, 0);

    // T6: reset while read is in REQ and write is in RESP
    step(); step();
    rd_mode = 0;
    s_awaddr = 32'h10; s_wdata = 32'h77; s_wstrb = 4'hF; s_araddr = 32'h14;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      aw_hs = s_awvalid && s_awready; w_hs = s_wvalid && s_wready; ar_hs = s_arvalid && s_arready;
      step();
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs) s_wvalid = 1'b0;
      if (ar_hs) s_arvalid = 1'b0;
      if (s_bvalid) break;
    end
    check("t6_pre_state", {s_bvalid, oReadValid, s_awvalid, s_arvalid}, 4'b1100);
    #2 iReset = 1'b1;
    #1;
    check("t6_rst_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, oWriteValid, oReadValid,
                          s_bresp, s_rresp}, 0);
    check("t6_rst_wdata", {oWriteAddress, oWriteData}, 0);
    check("t6_rst_rdata", {oReadAddress, s_rdata}, 0);
    step();
    iReset = 1'b0;
    step(); step();
    rd_mode = 1; iReadData = 32'hABCD;
    do_write(32'h20, 32'h99, 4'hF, 0, lat, vn, resp, sa, sd, done);
    check("t6_wr_bresp", resp, 2'b00);
    check("t6_wr_addr", sa, 32'h20);
    step(); step();
    do_read(32'h24, lat, vn, an, rd, resp, ra, done);
    check("t6_rd_rresp", resp, 2'b00);
    check("t6_rd_rdata", rd, 32'hABCD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
